// File: rtl/cv32e40p_tmr_mult_ctrl.sv
// Sequencing and voting controller for the triple-redundant multiplier.
// Runs three replicas in lockstep, votes word-wise, retries and tracks faults.
module cv32e40p_tmr_mult_ctrl #(
    parameter int TIMEOUT      = 16,
    parameter int MAX_RETRY    = 2,
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic        rep_enable_o,
    output logic        rep_ex_ready_o,
    input  logic [2:0]  rep_ready_i,
    input  logic [31:0] rep_result0_i,
    input  logic [31:0] rep_result1_i,
    input  logic [31:0] rep_result2_i,
    input  logic [2:0]  rep_cmp_i,
    output logic [31:0] result_o,
    output logic        comparison_result_o,
    output logic        valid_o,
    input  logic        ex_ready_i,
    output logic        err_uncorr_o,
    output logic [2:0]  fault_o
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        VOTE,
        RETRY,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              done_q, done_d;
    logic [2:0][32:0]        word_q, word_d;
    logic [2:0][32:0]        rep_word;
    logic [TW-1:0]           timer_q, timer_d;
    logic [RW-1:0]           retry_q, retry_d;
    logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]              fault_q, fault_d;
    logic [31:0]             result_q, result_d;
    logic                    cmp_q, cmp_d;
    logic                    err_q, err_d;

    logic                    busy_exit;
    logic                    m01, m02, m12, maj;
    logic [32:0]             win, fallback;
    logic [2:0]              miss_maj;

    assign rep_word[0] = {rep_cmp_i[0], rep_result0_i};
    assign rep_word[1] = {rep_cmp_i[1], rep_result1_i};
    assign rep_word[2] = {rep_cmp_i[2], rep_result2_i};

    // A replica raising ready in the timeout cycle still counts as done.
    assign busy_exit = (&(done_q | rep_ready_i))
                     || (timer_q == TW'(TIMEOUT - 1));

    assign m01 = done_q[0] && done_q[1] && (word_q[0] == word_q[1]);
    assign m02 = done_q[0] && done_q[2] && (word_q[0] == word_q[2]);
    assign m12 = done_q[1] && done_q[2] && (word_q[1] == word_q[2]);
    assign maj = m01 || m02 || m12;

    always_comb begin
        win = '0;
        if (m01 || m02) begin
            win = word_q[0];
        end else if (m12) begin
            win = word_q[1];
        end
    end

    always_comb begin
        fallback = '0;
        if (done_q[0]) begin
            fallback = word_q[0];
        end else if (done_q[1]) begin
            fallback = word_q[1];
        end else if (done_q[2]) begin
            fallback = word_q[2];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            miss_maj[i] = !done_q[i] || (word_q[i] != win);
        end
    end

    always_comb begin
        state_d        = state_q;
        done_d         = done_q;
        word_d         = word_q;
        timer_d        = timer_q;
        retry_d        = retry_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        cmp_d          = cmp_q;
        err_d          = err_q;
        req_ready_o    = 1'b0;
        rep_enable_o   = 1'b0;
        rep_ex_ready_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = BUSY;
                    done_d  = '0;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            BUSY: begin
                rep_enable_o = 1'b1;
                timer_d      = timer_q + TW'(1);
                for (int i = 0; i < 3; i++) begin
                    if (rep_ready_i[i] && !done_q[i]) begin
                        word_d[i] = rep_word[i];
                        done_d[i] = 1'b1;
                    end
                end
                if (busy_exit) begin
                    rep_ex_ready_o = 1'b1;
                    state_d        = VOTE;
                end
            end
            VOTE: begin
                if (maj) begin
                    result_d = win[31:0];
                    cmp_d    = win[32];
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + RW'(1);
                    state_d = RETRY;
                end else begin
                    result_d = fallback[31:0];
                    cmp_d    = fallback[32];
                    err_d    = 1'b1;
                    state_d  = DONE;
                end
                // Without a winner only missing replicas are blamed.
                for (int i = 0; i < 3; i++) begin
                    if ((maj && miss_maj[i]) || (!maj && !done_q[i])) begin
                        if (cnt_q[i] != {CNT_W{1'b1}}) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end
            RETRY: begin
                done_d  = '0;
                timer_d = '0;
                state_d = BUSY;
            end
            DONE: begin
                if (ex_ready_i) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            fault_d[i] = fault_q[i]
                       || (cnt_d[i] >= CNT_W'(FAULT_THRESH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= '0;
            word_q   <= '0;
            timer_q  <= '0;
            retry_q  <= '0;
            cnt_q    <= '0;
            fault_q  <= '0;
            result_q <= '0;
            cmp_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            word_q   <= word_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            result_q <= result_d;
            cmp_q    <= cmp_d;
            err_q    <= err_d;
        end
    end

    assign valid_o             = (state_q == DONE);
    assign result_o            = result_q;
    assign comparison_result_o = cmp_q;
    assign err_uncorr_o        = err_q;
    assign fault_o             = fault_q;

endmodule
